// File: rtl/uart_code_reporter.sv
// Formats a snapshot of a scanned code as "<PREFIX><digits>\r\n" and streams it byte by byte
// into a uart_tx style transmitter, triggered periodically, on change, manually, or a mix.
module uart_code_reporter #(
    parameter int             CLK_FRE    = 50,
    parameter int             UART_RATE  = 115200,
    parameter int             PERIOD_MS  = 500,
    parameter int             DIGITS     = 13,
    parameter logic [127:0]   PREFIX     = {88'd0, "Code:"},
    parameter int             PREFIX_LEN = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            mode,
    input  logic                  trig,
    input  logic [DIGITS*4-1:0]   scan_data,
    output logic                  send_en,
    output logic [7:0]            send_data,
    input  logic                  send_busy,
    output logic                  frame_busy,
    output logic                  frame_done,
    output logic [15:0]           frame_count
);

    localparam int PERIOD = CLK_FRE * PERIOD_MS * 1000;
    localparam int N      = PREFIX_LEN + DIGITS + 2;
    localparam int IDX_W  = $clog2(N);
    localparam int DW     = DIGITS * 4;
    localparam int SW     = $clog2(DW);
    localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    if (DIGITS < 1 || DIGITS > 32 || PREFIX_LEN < 0 || PREFIX_LEN > 16 || UART_RATE <= 0) begin : g_param_check
        $error("uart_code_reporter: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ARM,
        S_WAIT_HI,
        S_WAIT_LO,
        S_NEXT
    } state_t;

    function automatic logic [7:0] hex_ascii(input logic [3:0] v);
        if (v < 4'd10) begin
            hex_ascii = 8'h30 + {4'h0, v};
        end else begin
            hex_ascii = 8'h37 + {4'h0, v};
        end
    endfunction

    function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0] idx, input logic [DW-1:0] snap);
        int         i;
        logic [6:0] pbit;
        logic [SW-1:0] sbit;
        i    = int'(idx);
        pbit = 7'((PREFIX_LEN - 1 - i) * 8);
        sbit = SW'((i - PREFIX_LEN) * 4);
        if (i < PREFIX_LEN) begin
            frame_byte = PREFIX[pbit +: 8];
        end else if (i < PREFIX_LEN + DIGITS) begin
            frame_byte = hex_ascii(snap[sbit +: 4]);
        end else if (i == PREFIX_LEN + DIGITS) begin
            frame_byte = 8'h0D;
        end else begin
            frame_byte = 8'h0A;
        end
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_tick_cnt;
    logic               r_tick;
    logic               r_pending;
    logic [DW-1:0]      r_snap;
    logic [DW-1:0]      r_last;
    logic [IDX_W-1:0]   r_idx;
    logic [1:0]         r_wait_cnt;
    logic [7:0]         r_send_hold;
    logic               r_frame_busy;
    logic               r_frame_done;
    logic [15:0]        r_frame_count;

    logic               w_tick_en;
    logic               w_chg_en;
    logic               w_change;
    logic               w_event;
    logic               w_start;
    logic               w_strobe;
    logic               w_last_byte;
    logic               w_frame_end;
    logic [7:0]         w_byte;

    // Mode decode: which autonomous event sources may request a frame.
    always_comb begin
        w_tick_en = 1'b0;
        w_chg_en  = 1'b0;
        case (mode)
            2'd0:    begin w_tick_en = 1'b1; w_chg_en = 1'b0; end
            2'd1:    begin w_tick_en = 1'b0; w_chg_en = 1'b1; end
            2'd2:    begin w_tick_en = 1'b1; w_chg_en = 1'b1; end
            2'd3:    begin w_tick_en = 1'b0; w_chg_en = 1'b0; end
            default: begin w_tick_en = 1'b0; w_chg_en = 1'b0; end
        endcase
    end

    assign w_change    = (r_state == S_IDLE) && (scan_data != r_last);
    assign w_event     = (w_tick_en & r_tick) | (w_chg_en & w_change) | trig;
    assign w_start     = (r_state == S_IDLE) && (r_pending || w_event);
    assign w_last_byte = (r_idx == IDX_W'(N - 1));
    assign w_frame_end = (r_state == S_NEXT) && w_last_byte;
    assign w_byte      = frame_byte(r_idx, r_snap);

    // Next-state logic; the strobe is gated by reset so an abort issues nothing further.
    always_comb begin
        w_state_nxt = r_state;
        w_strobe    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pending || w_event) begin
                    w_state_nxt = S_START;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_START: begin
                w_state_nxt = S_ARM;
            end
            S_ARM: begin
                if (!send_busy) begin
                    w_strobe    = rst_n;
                    w_state_nxt = S_WAIT_HI;
                end else begin
                    w_state_nxt = S_ARM;
                end
            end
            S_WAIT_HI: begin
                if (send_busy) begin
                    w_state_nxt = S_WAIT_LO;
                end else if (r_wait_cnt == 2'd3) begin
                    w_state_nxt = S_NEXT;
                end else begin
                    w_state_nxt = S_WAIT_HI;
                end
            end
            S_WAIT_LO: begin
                if (!send_busy) begin
                    w_state_nxt = S_NEXT;
                end else begin
                    w_state_nxt = S_WAIT_LO;
                end
            end
            S_NEXT: begin
                if (w_last_byte) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_ARM;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register plus free-running period tick and event pending flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= '0;
            r_tick     <= 1'b0;
            r_pending  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_tick_cnt == CNT_W'(PERIOD - 1)) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + CNT_W'(1);
            end
            r_tick <= (r_tick_cnt == CNT_W'(PERIOD - 1));
            if (w_start) begin
                r_pending <= 1'b0;
            end else if (w_event) begin
                r_pending <= 1'b1;
            end
        end
    end

    // Frame datapath: snapshot, byte index, acceptance timeout and frame status.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_snap        <= '0;
            r_last        <= '0;
            r_idx         <= '0;
            r_wait_cnt    <= 2'd0;
            r_send_hold   <= 8'h00;
            r_frame_busy  <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_count <= 16'd0;
        end else begin
            if (r_state == S_START) begin
                r_snap <= scan_data;
                r_last <= scan_data;
                r_idx  <= '0;
            end else if ((r_state == S_NEXT) && !w_last_byte) begin
                r_idx <= r_idx + IDX_W'(1);
            end
            if (r_state == S_WAIT_HI) begin
                r_wait_cnt <= r_wait_cnt + 2'd1;
            end else begin
                r_wait_cnt <= 2'd0;
            end
            if (w_strobe) begin
                r_send_hold <= w_byte;
            end
            if (w_start) begin
                r_frame_busy <= 1'b1;
            end else if (w_frame_end) begin
                r_frame_busy <= 1'b0;
            end
            r_frame_done <= w_frame_end;
            if (w_frame_end) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    assign send_en     = w_strobe;
    assign send_data   = w_strobe ? w_byte : r_send_hold;
    assign frame_busy  = r_frame_busy;
    assign frame_done  = r_frame_done;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_uart_code_reporter.sv
// Directed bench for uart_code_reporter with a small uart_tx busy model; PERIOD is scaled to 1000 cycles.
module tb_uart_code_reporter;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    mode;
    logic          trig;
    logic [51:0]   scan_data;
    logic          send_en;
    logic [7:0]    send_data;
    logic          send_busy;
    logic          frame_busy;
    logic          frame_done;
    logic [15:0]   frame_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_code_reporter #(
        .CLK_FRE    (1),
        .UART_RATE  (115200),
        .PERIOD_MS  (1),
        .DIGITS     (13),
        .PREFIX     ({88'd0, "Code:"}),
        .PREFIX_LEN (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode        (mode),
        .trig        (trig),
        .scan_data   (scan_data),
        .send_en     (send_en),
        .send_data   (send_data),
        .send_busy   (send_busy),
        .frame_busy  (frame_busy),
        .frame_done  (frame_done),
        .frame_count (frame_count)
    );

    // uart_tx model: busy for busy_len cycles after each accepted strobe
    int busy_len = 3;
    int busy_cnt = 0;
    always @(posedge clk) begin
        if (send_en) busy_cnt <= busy_len;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign send_busy = (busy_cnt != 0);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int           strobe_cnt = 0;
    int           viol_cnt = 0;
    int           done_cnt = 0;
    int           last_done_cyc = 0;
    int           rise_cyc = 0;
    int           last_strobe_cyc = 0;
    int           prev_strobe_cyc = 0;
    logic [159:0] mon_acc = '0;
    logic         prev_busy = 1'b0;

    always @(negedge clk) begin
        if (send_en) begin
            strobe_cnt      <= strobe_cnt + 1;
            mon_acc         <= {mon_acc[151:0], send_data};
            prev_strobe_cyc <= last_strobe_cyc;
            last_strobe_cyc <= cyc;
            if (send_busy) viol_cnt <= viol_cnt + 1;
        end
        if (frame_done) begin
            done_cnt      <= done_cnt + 1;
            last_done_cyc <= cyc;
        end
        if (frame_busy && !prev_busy) rise_cyc <= cyc;
        prev_busy <= frame_busy;
    end

    task automatic wait_done(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done_cnt >= target) break;
            @(negedge clk);
        end
    endtask

    task automatic wait_strobes(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (strobe_cnt >= target) break;
            @(negedge clk);
        end
    endtask

    task automatic pulse_trig();
        @(negedge clk);
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mode = 2'd0;
        trig = 1'b0;
        scan_data = 52'hDCBA987654321;
        busy_len = 3;
        repeat (5) @(negedge clk);
        n_tests++; if (send_en !== 1'b0) begin n_fail++; $display("FAIL reset_send_en: got %0b expected 0", send_en); end
        n_tests++; if (send_data !== 8'h00) begin n_fail++; $display("FAIL reset_send_data: got %h expected 00", send_data); end
        n_tests++; if (frame_busy !== 1'b0) begin n_fail++; $display("FAIL reset_frame_busy: got %0b expected 0", frame_busy); end
        n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %0b expected 0", frame_done); end
        n_tests++; if (frame_count !== 16'd0) begin n_fail++; $display("FAIL reset_frame_count: got %0d expected 0", frame_count); end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_periodic();
        int d0 = done_cnt;
        int s0 = strobe_cnt;
        int t1;
        logic [159:0] exp_a = {"Code:123456789ABCD", 8'h0D, 8'h0A};
        wait_done(d0 + 1, 1500);
        n_tests++; if (done_cnt !== d0 + 1) begin n_fail++; $display("FAIL periodic_first_frame: got %0d frames expected 1", done_cnt - d0); end
        n_tests++; if (strobe_cnt - s0 !== 20) begin n_fail++; $display("FAIL periodic_len: got %0d bytes expected 20", strobe_cnt - s0); end
        n_tests++; if (mon_acc !== exp_a) begin n_fail++; $display("FAIL periodic_text: got %h expected %h", mon_acc, exp_a); end
        n_tests++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL periodic_count1: got %0d expected 1", frame_count); end
        t1 = last_done_cyc;
        wait_done(d0 + 2, 1500);
        n_tests++; if (last_done_cyc - t1 !== 1000) begin n_fail++; $display("FAIL periodic_interval: got %0d expected 1000", last_done_cyc - t1); end
        n_tests++; if (frame_count !== 16'd2) begin n_fail++; $display("FAIL periodic_count2: got %0d expected 2", frame_count); end
        n_tests++; if (mon_acc !== exp_a) begin n_fail++; $display("FAIL periodic_text2: got %h expected %h", mon_acc, exp_a); end
    endtask

    task automatic test_on_change();
        int d0;
        int s0;
        logic [159:0] exp_5 = {"Code:5000000000000", 8'h0D, 8'h0A};
        @(posedge clk); #1 rst_n = 1'b0;
        mode = 2'd1;
        scan_data = 52'h0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        d0 = done_cnt;
        s0 = strobe_cnt;
        repeat (2500) @(negedge clk);
        n_tests++; if (done_cnt !== d0) begin n_fail++; $display("FAIL change_quiet_frames: got %0d expected 0", done_cnt - d0); end
        n_tests++; if (strobe_cnt !== s0) begin n_fail++; $display("FAIL change_quiet_strobes: got %0d expected 0", strobe_cnt - s0); end
        scan_data = 52'h5;
        wait_done(d0 + 1, 500);
        n_tests++; if (done_cnt !== d0 + 1) begin n_fail++; $display("FAIL change_frame: got %0d frames expected 1", done_cnt - d0); end
        n_tests++; if (mon_acc !== exp_5) begin n_fail++; $display("FAIL change_text: got %h expected %h", mon_acc, exp_5); end
        n_tests++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL change_count: got %0d expected 1", frame_count); end
        repeat (1500) @(negedge clk);
        n_tests++; if (done_cnt !== d0 + 1) begin n_fail++; $display("FAIL change_held_silence: got %0d frames expected 1", done_cnt - d0); end
    endtask

    task automatic test_snapshot();
        int d0 = done_cnt;
        int s0 = strobe_cnt;
        int t1;
        logic [159:0] exp_a = {"Code:123456789ABCD", 8'h0D, 8'h0A};
        logic [159:0] exp_7 = {"Code:7777777777777", 8'h0D, 8'h0A};
        scan_data = 52'hDCBA987654321;
        wait_strobes(s0 + 8, 300);
        n_tests++; if (strobe_cnt < s0 + 8) begin n_fail++; $display("FAIL snap_reach_byte8: got %0d bytes expected 8", strobe_cnt - s0); end
        scan_data = 52'h7777777777777;
        wait_done(d0 + 1, 500);
        n_tests++; if (mon_acc !== exp_a) begin n_fail++; $display("FAIL snap_text: got %h expected %h", mon_acc, exp_a); end
        t1 = last_done_cyc;
        wait_done(d0 + 2, 500);
        n_tests++; if (done_cnt !== d0 + 2) begin n_fail++; $display("FAIL snap_followup: got %0d frames expected 2", done_cnt - d0); end
        n_tests++; if (rise_cyc !== t1 + 1) begin n_fail++; $display("FAIL snap_b2b_start: got %0d expected %0d", rise_cyc, t1 + 1); end
        n_tests++; if (mon_acc !== exp_7) begin n_fail++; $display("FAIL snap_followup_text: got %h expected %h", mon_acc, exp_7); end
        repeat (1500) @(negedge clk);
        n_tests++; if (done_cnt !== d0 + 2) begin n_fail++; $display("FAIL snap_silence: got %0d frames expected 2", done_cnt - d0); end
    endtask

    task automatic test_manual();
        int d0 = done_cnt;
        int s0 = strobe_cnt;
        logic [159:0] exp_7 = {"Code:7777777777777", 8'h0D, 8'h0A};
        logic [159:0] exp_h = {"Code:3456789ABCDEF", 8'h0D, 8'h0A};
        @(negedge clk);
        mode = 2'd3;
        pulse_trig();
        for (int th = 3; th <= 9; th += 3) begin
            wait_strobes(s0 + th, 200);
            if (th == 3) scan_data = 52'hFEDCBA9876543;
            pulse_trig();
        end
        wait_done(d0 + 1, 500);
        n_tests++; if (mon_acc !== exp_7) begin n_fail++; $display("FAIL manual_text1: got %h expected %h", mon_acc, exp_7); end
        wait_done(d0 + 2, 500);
        n_tests++; if (done_cnt !== d0 + 2) begin n_fail++; $display("FAIL manual_extra_frame: got %0d frames expected 2", done_cnt - d0); end
        n_tests++; if (mon_acc !== exp_h) begin n_fail++; $display("FAIL manual_text2: got %h expected %h", mon_acc, exp_h); end
        scan_data = 52'h1111111111111;
        repeat (2500) @(negedge clk);
        n_tests++; if (done_cnt !== d0 + 2) begin n_fail++; $display("FAIL manual_silence: got %0d frames expected 2", done_cnt - d0); end
    endtask

    task automatic test_busy();
        int d0 = done_cnt;
        int s0 = strobe_cnt;
        int v0 = viol_cnt;
        logic [159:0] exp_1 = {"Code:1111111111111", 8'h0D, 8'h0A};
        busy_len = 100;
        pulse_trig();
        wait_done(d0 + 1, 3000);
        n_tests++; if (done_cnt !== d0 + 1) begin n_fail++; $display("FAIL busy_frame: got %0d frames expected 1", done_cnt - d0); end
        n_tests++; if (viol_cnt !== v0) begin n_fail++; $display("FAIL busy_strobe_while_busy: got %0d expected 0", viol_cnt - v0); end
        n_tests++; if (strobe_cnt - s0 !== 20) begin n_fail++; $display("FAIL busy_len: got %0d bytes expected 20", strobe_cnt - s0); end
        n_tests++; if (mon_acc !== exp_1) begin n_fail++; $display("FAIL busy_text: got %h expected %h", mon_acc, exp_1); end
        n_tests++; if (last_strobe_cyc - prev_strobe_cyc !== 103) begin n_fail++; $display("FAIL busy_byte_spacing: got %0d expected 103", last_strobe_cyc - prev_strobe_cyc); end
    endtask

    task automatic test_timeout();
        int d0 = done_cnt;
        int s0 = strobe_cnt;
        logic [159:0] exp_1 = {"Code:1111111111111", 8'h0D, 8'h0A};
        busy_len = 0;
        pulse_trig();
        wait_done(d0 + 1, 400);
        n_tests++; if (done_cnt !== d0 + 1) begin n_fail++; $display("FAIL timeout_frame: got %0d frames expected 1", done_cnt - d0); end
        n_tests++; if (strobe_cnt - s0 !== 20) begin n_fail++; $display("FAIL timeout_len: got %0d bytes expected 20", strobe_cnt - s0); end
        n_tests++; if (mon_acc !== exp_1) begin n_fail++; $display("FAIL timeout_text: got %h expected %h", mon_acc, exp_1); end
        n_tests++; if (last_strobe_cyc - prev_strobe_cyc !== 6) begin n_fail++; $display("FAIL timeout_byte_spacing: got %0d expected 6", last_strobe_cyc - prev_strobe_cyc); end
    endtask

    task automatic test_reset_midframe();
        int s0 = strobe_cnt;
        int s1;
        busy_len = 3;
        pulse_trig();
        wait_strobes(s0 + 10, 300);
        n_tests++; if (strobe_cnt < s0 + 10) begin n_fail++; $display("FAIL rstmid_reach_byte10: got %0d bytes expected 10", strobe_cnt - s0); end
        @(posedge clk); #1 rst_n = 1'b0;
        s1 = strobe_cnt;
        @(posedge clk);
        @(negedge clk);
        n_tests++; if (send_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_send_en: got %0b expected 0", send_en); end
        n_tests++; if (send_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_send_data: got %h expected 00", send_data); end
        n_tests++; if (frame_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_frame_busy: got %0b expected 0", frame_busy); end
        n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_frame_done: got %0b expected 0", frame_done); end
        n_tests++; if (frame_count !== 16'd0) begin n_fail++; $display("FAIL rstmid_frame_count: got %0d expected 0", frame_count); end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (300) @(negedge clk);
        n_tests++; if (strobe_cnt !== s1) begin n_fail++; $display("FAIL rstmid_no_strobes: got %0d expected 0", strobe_cnt - s1); end
        n_tests++; if (frame_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: got %0b expected 0", frame_busy); end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_on_change();
        test_snapshot();
        test_manual();
        test_busy();
        test_timeout();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_code_reporter.md
# uart_code_reporter

Parametrised frame generator that formats a scanned code into an ASCII text line and streams it byte-by-byte into the existing `uart_tx` byte transmitter. It generalises the fixed 13-digit, fixed-period "Code:" sender with a configurable digit count, a configurable period, hex-capable digit encoding, a snapshot of the data at frame start, and selectable trigger modes (periodic, on-change, both, or manual). It sits between the barcode scan matrix and `uart_tx`.

## Interface
Parameters:
- `CLK_FRE`, 50: clock frequency in MHz.
- `UART_RATE`, 115200: informational only; passed through by the top level to `uart_tx`.
- `PERIOD_MS`, 500: periodic report interval in ms; the tick period is `CLK_FRE*PERIOD_MS*1000` cycles.
- `DIGITS`, 13: number of 4-bit digits per frame, 1..32.
- `PREFIX`, "Code:": ASCII prefix string.
- `PREFIX_LEN`, 5: prefix byte count, 0..16.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `mode`  in  2  trigger mode: 0 = periodic, 1 = on-change, 2 = periodic or on-change, 3 = manual only.
- `trig`  in  1  manual trigger, level-sampled per cycle; honoured in all modes.
- `scan_data`  in  DIGITS*4  digit k (sent k-th) is `scan_data[k*4 +: 4]`.
- `send_en`  out  1  one-cycle byte strobe to `uart_tx`.
- `send_data`  out  8  byte valid while `send_en`=1; held until the next strobe.
- `send_busy`  in  1  busy flag from `uart_tx`.
- `frame_busy`  out  1  high from frame start until the last byte completes.
- `frame_done`  out  1  one-cycle pulse after the last byte completes.
- `frame_count`  out  16  frames completed; wraps from 0xFFFF to 0.

## Operation
- Frame layout: `PREFIX` (MSB byte first), then `DIGITS` characters, then 0x0D, 0x0A. Total frame length is `N = PREFIX_LEN+DIGITS+2` bytes.
- Digit encoding: a value v of 0..9 is sent as 0x30+v. A value v of 10..15 is sent as 0x41+v-10 ('A'..'F').
- Snapshot: `scan_data` is registered into `snap` at frame start. All digits in the frame come from `snap`; changes to the input during a frame do not alter it.
- Change detection: `last` holds the `snap` value of the most recently started frame. On-change means `scan_data != last` while IDLE. `last` resets to 0.
- Period tick: a free-running counter runs from reset, independent of frames. When it reaches `PERIOD-1` it emits a tick and returns to 0.
- Pending flag: a single bit, set by any enabled event (tick in modes 0 and 2, change in modes 1 and 2, `trig` in all modes). Events arriving while `frame_busy`=1 set the flag. Multiple events collapse into one frame. The flag is cleared at frame start.
- FSM:
  - IDLE: if pending or an event is present this cycle → START.
  - START: capture `snap` and `last`, set `idx`=0, assert `frame_busy` → ARM.
  - ARM: when `send_busy`=0, drive `send_en`=1 with byte[idx] → WAIT_HI.
  - WAIT_HI: on `send_busy`=1 → WAIT_LO. If `send_busy` stays low for 4 cycles, the byte counts as accepted → NEXT.
  - WAIT_LO: on `send_busy`=0 → NEXT.
  - NEXT: if `idx==N-1`: pulse `frame_done`, increment `frame_count`, clear `frame_busy`, go to IDLE. Otherwise increment `idx` and go to ARM.
- Reset mid-frame: the frame is aborted immediately and no further strobes are issued. A byte already in `uart_tx` completes on its own.
- Mode changes take effect on the next event evaluation. A frame in progress always completes.

## Timing
- Reset values: `send_en`=0, `send_data`=0x00, `frame_busy`=0, `frame_done`=0, `frame_count`=0. Internally: pending=0, tick counter=0, FSM=IDLE.
- Event to first strobe: an event in cycle t while IDLE (with `send_busy`=0) gives START at t+1, `send_en` at t+2.
- Exactly one strobe is issued per byte. Strobes are never issued while `send_busy`=1.
- `frame_done` is asserted in the cycle after the WAIT_LO exit for byte N-1. `frame_busy` falls in the same cycle.
- Back-to-back frames: if pending=1 at `frame_done`, START follows 1 cycle later.
- First periodic frame: the tick comes `PERIOD` cycles after reset release.

## Test plan
- Mode 0, `PERIOD_MS` scaled so PERIOD=1000, `scan_data` digits 1..9,A,B,C,D, uart_tx model → "Code:123456789ABCD\r\n" (20 bytes) every 1000 cycles; `frame_count` increments by 1 per frame.
- Mode 1: hold `scan_data` at 0 → no frames. Change digit 0 to 5 → exactly one frame "Code:5000000000000\r\n", then silence while the input is held.
- Snapshot: change `scan_data` at byte 8 of a frame → the current frame is unchanged. In mode 1 exactly one follow-up frame starts 1 cycle after `frame_done`.
- Mode 3: pulse `trig` three times during one frame → exactly one extra frame; ticks and changes produce nothing.
- Busy handling: the model holds `send_busy` high for 100 cycles per byte → no `send_en` while busy. A model that never raises busy → byte index advances after the 4-cycle timeout.
- Reset: assert `rst_n`=0 at byte 10 → the next cycle shows all outputs at reset values, and no strobes until a new event.
